// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, slave indices and default memory map for the bus controller
//
// Contents:
//   state_t          controller sequencing states
//   SLV_*            bit positions of each slave in the one-hot select
//   NUM_SLAVES       number of on-chip slaves
//   DEF_*            default memory map and timeout
//   in_window()      base <= addr < base+size, evaluated 33 bits wide
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int NUM_SLAVES = 3;
    localparam int SLV_ROM    = 0;
    localparam int SLV_RAM    = 1;
    localparam int SLV_IO     = 2;

    localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_ROM_SIZE = 32'h0000_1000;
    localparam logic [31:0] DEF_RAM_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_RAM_SIZE = 32'h0000_1000;
    localparam logic [31:0] DEF_IO_BASE  = 32'h1000_0000;
    localparam int          DEF_TIMEOUT  = 15;

    // The upper bound is formed with a carry bit so a window ending at the
    // top of the address space does not wrap to zero.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] limit;
        limit = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/addr_decoder.sv
// rtl/addr_decoder.sv - combinational memory-map decode and access legality check
//
// Ports:
//   addr     in   32  byte address of the request
//   instr    in   1   request is an instruction fetch
//   write    in   1   request is a write
//   hit      out  3   one-hot window hit: [0] ROM, [1] RAM, [2] IO
//   illegal  out  1   request must be answered with a bus error
module addr_decoder
    import bus_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE
) (
    input  logic [31:0]           addr,
    input  logic                  instr,
    input  logic                  write,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  illegal
);

    logic in_rom;
    logic in_ram;
    logic in_io;

    // Fixed priority ROM > RAM > IO keeps hit one-hot even if a custom
    // memory map makes windows overlap.
    assign in_rom = in_window(addr, ROM_BASE, ROM_SIZE);
    assign in_ram = !in_rom && in_window(addr, RAM_BASE, RAM_SIZE);
    assign in_io  = !in_rom && !in_ram && (addr >= IO_BASE);

    always_comb begin
        hit          = '0;
        hit[SLV_ROM] = in_rom;
        hit[SLV_RAM] = in_ram;
        hit[SLV_IO]  = in_io;

        // ROM serves fetches only and is read-only; RAM and IO serve data only.
        // Anything that hits no window is an error.
        illegal = 1'b1;
        if (in_rom) begin
            illegal = !instr || write;
        end else if (in_ram || in_io) begin
            illegal = instr;
        end
    end

endmodule

// File: rtl/bus_controller.sv
// rtl/bus_controller.sv - sequences the CPU native memory interface onto ROM, RAM and IO
//
// Ports:
//   clk_in, reset_n_in          clock, asynchronous active-low reset
//   cpu_valid_in/instr/addr/wstrb  CPU request (wstrb != 0 means write)
//   cpu_ready_out, cpu_rdata_out   one-cycle completion pulse and read data
//   sel_out, write_out             one-hot slave select and write flag
//   slave_ready_in                 per-slave ready, same bit order as sel_out
//   rom/ram/io_rdata_in            slave read data
//   err_out, err_addr_out          sticky bus error and faulting address
//   err_clear_in                   clears err_out on the next cycle
module bus_controller
    import bus_pkg::*;
#(
    parameter logic [31:0] ROM_BASE = DEF_ROM_BASE,
    parameter logic [31:0] ROM_SIZE = DEF_ROM_SIZE,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] RAM_SIZE = DEF_RAM_SIZE,
    parameter logic [31:0] IO_BASE  = DEF_IO_BASE,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  cpu_valid_in,
    input  logic                  cpu_instr_in,
    input  logic [31:0]           cpu_addr_in,
    input  logic [3:0]            cpu_wstrb_in,
    output logic                  cpu_ready_out,
    output logic [31:0]           cpu_rdata_out,
    output logic [NUM_SLAVES-1:0] sel_out,
    output logic                  write_out,
    input  logic [NUM_SLAVES-1:0] slave_ready_in,
    input  logic [31:0]           rom_rdata_in,
    input  logic [31:0]           ram_rdata_in,
    input  logic [31:0]           io_rdata_in,
    output logic                  err_out,
    output logic [31:0]           err_addr_out,
    input  logic                  err_clear_in
);

    // The counter holds the number of ACCESS cycles already spent without
    // ready, so the last permitted cycle is the one where it equals TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t                  state;
    logic [31:0]             addr_q;
    logic [7:0]              cnt;
    logic [NUM_SLAVES-1:0]   dec_hit;
    logic                    dec_illegal;
    logic [31:0]             sel_rdata;
    logic                    sel_ready;

    addr_decoder #(
        .ROM_BASE (ROM_BASE),
        .ROM_SIZE (ROM_SIZE),
        .RAM_BASE (RAM_BASE),
        .RAM_SIZE (RAM_SIZE),
        .IO_BASE  (IO_BASE)
    ) u_addr_decoder (
        .addr    (cpu_addr_in),
        .instr   (cpu_instr_in),
        .write   (|cpu_wstrb_in),
        .hit     (dec_hit),
        .illegal (dec_illegal)
    );

    // Only the selected slave's ready counts; the others are masked off.
    assign sel_ready = |(sel_out & slave_ready_in);

    always_comb begin
        sel_rdata = '0;
        if (sel_out[SLV_ROM]) begin
            sel_rdata = rom_rdata_in;
        end else if (sel_out[SLV_RAM]) begin
            sel_rdata = ram_rdata_in;
        end else if (sel_out[SLV_IO]) begin
            sel_rdata = io_rdata_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= IDLE;
            addr_q        <= '0;
            cnt           <= '0;
            sel_out       <= '0;
            write_out     <= 1'b0;
            cpu_ready_out <= 1'b0;
            cpu_rdata_out <= '0;
            err_out       <= 1'b0;
            err_addr_out  <= '0;
        end else begin
            cpu_ready_out <= 1'b0;

            // A fault raised further down in the same cycle overrides this.
            if (err_clear_in) begin
                err_out <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cpu_valid_in) begin
                        addr_q <= cpu_addr_in;
                        if (dec_illegal) begin
                            cpu_rdata_out <= '0;
                            cpu_ready_out <= 1'b1;
                            err_out       <= 1'b1;
                            err_addr_out  <= cpu_addr_in;
                            state         <= DONE;
                        end else begin
                            sel_out   <= dec_hit;
                            write_out <= |cpu_wstrb_in;
                            cnt       <= '0;
                            state     <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (sel_ready) begin
                        cpu_rdata_out <= sel_rdata;
                        cpu_ready_out <= 1'b1;
                        sel_out       <= '0;
                        write_out     <= 1'b0;
                        state         <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cpu_rdata_out <= '0;
                        cpu_ready_out <= 1'b1;
                        sel_out       <= '0;
                        write_out     <= 1'b0;
                        err_out       <= 1'b1;
                        err_addr_out  <= addr_q;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                // cpu_ready_out is high for this single cycle; the request
                // inputs are deliberately not looked at here.
                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
// tb/tb_bus_controller.sv - self-checking bench for bus_controller
module tb_bus_controller;

    localparam int TIMEOUT = 15;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        cpu_valid_in;
    logic        cpu_instr_in;
    logic [31:0] cpu_addr_in;
    logic [3:0]  cpu_wstrb_in;
    logic        cpu_ready_out;
    logic [31:0] cpu_rdata_out;
    logic [2:0]  sel_out;
    logic        write_out;
    logic [2:0]  slave_ready_in;
    logic [31:0] rom_rdata_in;
    logic [31:0] ram_rdata_in;
    logic [31:0] io_rdata_in;
    logic        err_out;
    logic [31:0] err_addr_out;
    logic        err_clear_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model of the sticky error state
    logic        m_err;
    logic [31:0] m_err_addr;

    always #5 clk_in = ~clk_in;

    bus_controller dut (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .cpu_valid_in   (cpu_valid_in),
        .cpu_instr_in   (cpu_instr_in),
        .cpu_addr_in    (cpu_addr_in),
        .cpu_wstrb_in   (cpu_wstrb_in),
        .cpu_ready_out  (cpu_ready_out),
        .cpu_rdata_out  (cpu_rdata_out),
        .sel_out        (sel_out),
        .write_out      (write_out),
        .slave_ready_in (slave_ready_in),
        .rom_rdata_in   (rom_rdata_in),
        .ram_rdata_in   (ram_rdata_in),
        .io_rdata_in    (io_rdata_in),
        .err_out        (err_out),
        .err_addr_out   (err_addr_out),
        .err_clear_in   (err_clear_in)
    );

    function automatic bit in_win(logic [31:0] a, longint base, longint size);
        longint la;
        la = longint'({32'd0, a});
        return (la >= base) && (la < base + size);
    endfunction

    // One complete CPU transaction. The slave answers on the bit the memory
    // map says it should, w cycles after selection; the model predicts
    // latency, select, data and error from the address map rules.
    task automatic do_txn(input logic [31:0] a, input logic instr, input logic [3:0] ws,
                          input int w, input bit noise, input bit clr, input string name);
        bit          wr, rom, ram, io, legal, tmo;
        logic [2:0]  exp_sel;
        logic [31:0] exp_rdata, d_rom, d_ram, d_io;
        int          lat;
        bit          exp_rdy;
        logic [2:0]  exp_s;
        logic        exp_w;
        logic [2:0]  rdy;

        wr  = (ws != 4'd0);
        rom = in_win(a, 64'h0, 64'h1000);
        ram = in_win(a, 64'h1000, 64'h1000);
        io  = (a >= 32'h1000_0000);
        legal   = (rom && instr && !wr) || (ram && !instr) || (io && !instr);
        exp_sel = !legal ? 3'b000 : rom ? 3'b001 : ram ? 3'b010 : 3'b100;
        tmo     = legal && (w >= TIMEOUT);
        lat     = !legal ? 1 : tmo ? TIMEOUT + 1 : w + 2;

        d_rom = $urandom; d_ram = $urandom; d_io = $urandom;
        exp_rdata = (!legal || tmo) ? 32'd0 : rom ? d_rom : ram ? d_ram : d_io;

        @(negedge clk_in);
        rom_rdata_in = d_rom; ram_rdata_in = d_ram; io_rdata_in = d_io;
        cpu_valid_in = 1'b1; cpu_addr_in = a; cpu_instr_in = instr; cpu_wstrb_in = ws;
        err_clear_in = clr;
        slave_ready_in = 3'b000;
        @(posedge clk_in);
        if (clr) m_err = 1'b0;
        if (!legal) begin m_err = 1'b1; m_err_addr = a; end

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                cpu_valid_in = 1'b0; err_clear_in = 1'b0;
                cpu_addr_in = $urandom; cpu_instr_in = $urandom_range(0, 1); cpu_wstrb_in = 4'($urandom);
            end
            exp_rdy = (k == lat);
            exp_s   = (legal && k < lat) ? exp_sel : 3'b000;
            exp_w   = legal && wr && (k < lat);
            n_cmp++;
            if (cpu_ready_out !== exp_rdy) begin
                n_fail++;
                $display("FAIL %s ready k=%0d: got %b expected %b", name, k, cpu_ready_out, exp_rdy);
            end
            n_cmp++;
            if (sel_out !== exp_s) begin
                n_fail++;
                $display("FAIL %s sel k=%0d: got %b expected %b", name, k, sel_out, exp_s);
            end
            n_cmp++;
            if (write_out !== exp_w) begin
                n_fail++;
                $display("FAIL %s write k=%0d: got %b expected %b", name, k, write_out, exp_w);
            end
            if (k == lat) begin
                if (tmo) begin m_err = 1'b1; m_err_addr = a; end
                n_cmp++;
                if (cpu_rdata_out !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h expected %h", name, cpu_rdata_out, exp_rdata);
                end
                n_cmp++;
                if (err_out !== m_err) begin
                    n_fail++;
                    $display("FAIL %s err: got %b expected %b", name, err_out, m_err);
                end
                n_cmp++;
                if (m_err && err_addr_out !== m_err_addr) begin
                    n_fail++;
                    $display("FAIL %s err_addr: got %h expected %h", name, err_addr_out, m_err_addr);
                end
            end
            rdy = noise ? (3'($urandom) & ~exp_sel) : 3'b000;
            if (legal && (k - 1 == w)) rdy = rdy | exp_sel;
            slave_ready_in = rdy;
        end
        slave_ready_in = 3'b000;
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({sel_out, write_out, cpu_ready_out, err_out} !== 6'd0 ||
            cpu_rdata_out !== 32'd0 || err_addr_out !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: sel=%b wr=%b rdy=%b err=%b rdata=%h eaddr=%h expected all 0",
                     name, sel_out, write_out, cpu_ready_out, err_out, cpu_rdata_out, err_addr_out);
        end
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0;
        cpu_valid_in = 1'b0; cpu_instr_in = 1'b0; cpu_addr_in = '0; cpu_wstrb_in = '0;
        slave_ready_in = '0; rom_rdata_in = '0; ram_rdata_in = '0; io_rdata_in = '0;
        err_clear_in = 1'b0;
        m_err = 1'b0; m_err_addr = '0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        reset_n_in = 1'b1;
        @(negedge clk_in);
        check_all_zero("after_reset_release");
    endtask

    task automatic test_rom_fetch();
        do_txn(32'h0000_0010, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "rom_fetch");
    endtask

    task automatic test_ram_write_wait();
        do_txn(32'h0000_1004, 1'b0, 4'b1111, 2, 1'b0, 1'b0, "ram_write_wait");
    endtask

    task automatic test_illegal();
        do_txn(32'h0000_0100, 1'b0, 4'b1111, 0, 1'b0, 1'b0, "illegal_rom_write");
        do_txn(32'h1000_0000, 1'b1, 4'b0000, 0, 1'b0, 1'b0, "illegal_io_fetch");
    endtask

    task automatic test_timeout();
        do_txn(32'h1000_0000, 1'b0, 4'b0000, 1000, 1'b1, 1'b0, "timeout");
        do_txn(32'h0000_1800, 1'b0, 4'b0000, TIMEOUT - 1, 1'b1, 1'b0, "ready_on_last_cycle");
    endtask

    task automatic test_err_clear_race();
        do_txn(32'h0000_3000, 1'b0, 4'b0000, 0, 1'b0, 1'b1, "clear_race");
        @(negedge clk_in);
        err_clear_in = 1'b1;
        @(posedge clk_in);
        m_err = 1'b0;
        @(negedge clk_in);
        err_clear_in = 1'b0;
        n_cmp++;
        if (err_out !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_alone err: got %b expected 0", err_out);
        end
        n_cmp++;
        if (err_addr_out !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL clear_alone err_addr: got %h expected 00003000", err_addr_out);
        end
    endtask

    task automatic test_reset_mid_access();
        int pulses;
        // leave a sticky error behind so reset visibly clears it
        do_txn(32'h0000_5000, 1'b0, 4'b0000, 0, 1'b0, 1'b0, "pre_reset_fault");
        @(negedge clk_in);
        io_rdata_in = 32'hDEAD_BEEF;
        cpu_valid_in = 1'b1; cpu_addr_in = 32'h1000_0010; cpu_instr_in = 1'b0; cpu_wstrb_in = 4'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        cpu_valid_in = 1'b0;
        @(negedge clk_in);
        #2 reset_n_in = 1'b0;
        #1 check_all_zero("async_reset_mid_access");
        m_err = 1'b0; m_err_addr = '0;
        repeat (2) @(negedge clk_in);
        reset_n_in = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (cpu_ready_out === 1'b1 || sel_out !== 3'b000) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL no_ready_after_reset: got %0d active cycles expected 0", pulses);
        end
        do_txn(32'h0000_1010, 1'b0, 4'b0000, 1, 1'b0, 1'b0, "after_reset_ram_read");
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [8];
        edges = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_1FFC, 32'h0000_2000,
                  32'h0FFF_FFFC, 32'h1000_0000, 32'hFFFF_FFFC, 32'h0000_0000};
        case ($urandom_range(0, 4))
            0: return $urandom_range(0, 32'h0000_0FFF);
            1: return $urandom_range(32'h0000_1000, 32'h0000_1FFF);
            2: return $urandom_range(32'h1000_0000, 32'hFFFF_FFFF);
            3: return $urandom_range(32'h0000_2000, 32'h0FFF_FFFF);
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a;
        logic        instr;
        logic [3:0]  ws;
        int          w;
        for (int i = 0; i < 80; i++) begin
            a     = rand_addr();
            instr = 1'($urandom_range(0, 1));
            ws    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            case ($urandom_range(0, 5))
                0: w = TIMEOUT - 1;
                1: w = TIMEOUT;
                2: w = TIMEOUT + 5;
                default: w = $urandom_range(0, 3);
            endcase
            do_txn(a, instr, ws, w, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0), $sformatf("random%0d", i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rom_fetch();
        test_ram_write_wait();
        test_illegal();
        test_timeout();
        test_err_clear_race();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Sequences the picorv32 native memory interface onto the three on-chip slaves: ROM, RAM and IO register.
- Decodes the address, asserts exactly one slave select, and waits for that slave's ready.
- Returns read data to the CPU with a single-cycle ready.
- Turns illegal accesses and stalled slaves into a bus error instead of a hung CPU.
- Sits between the cpu instance and the memory/io instances in the top level and replaces the ad-hoc enable logic and wired-together ready/rdata nets.

Parameters:
ROM_BASE, 32'h0000_0000, ROM window base (instruction fetch only, read only)
ROM_SIZE, 32'h0000_1000, ROM window size in bytes
RAM_BASE, 32'h0000_1000, RAM window base (data only)
RAM_SIZE, 32'h0000_1000, RAM window size in bytes
IO_BASE, 32'h1000_0000, IO window base; window extends to 32'hFFFF_FFFF (data only)
TIMEOUT, 15, cycles in ACCESS without slave ready before bus error (range 1..255)

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
cpu_valid_in  input  1  CPU mem_valid
cpu_instr_in  input  1  CPU mem_instr
cpu_addr_in  input  32  CPU byte address
cpu_wstrb_in  input  4  CPU byte write strobes; nonzero means write
cpu_ready_out  output  1  one-cycle completion pulse to CPU
cpu_rdata_out  output  32  read data, valid while cpu_ready_out is high
sel_out  output  3  one-hot slave select: [0] ROM, [1] RAM, [2] IO
write_out  output  1  write flag to the selected slave
slave_ready_in  input  3  per-slave ready, same bit order as sel_out
rom_rdata_in  input  32  ROM read data
ram_rdata_in  input  32  RAM read data
io_rdata_in  input  32  IO read data
err_out  output  1  sticky bus-error flag
err_addr_out  output  32  address of the most recent faulting access
err_clear_in  input  1  synchronous clear of err_out

Behaviour:
- Reset, applied asynchronously: state IDLE; sel_out, write_out, cpu_ready_out and err_out at 0; cpu_rdata_out and err_addr_out at 0; timeout counter at 0. Reset in mid-transaction aborts it, and no ready is issued afterwards.
- States: IDLE, ACCESS, DONE.
- IDLE: sample cpu_valid_in=1 in cycle T, then decode cpu_addr_in and latch the address and write flag (|cpu_wstrb_in).
  - Legal access: ROM read with instr=1; RAM read or write with instr=0; IO read or write with instr=0. Next state ACCESS. sel_out is one-hot and write_out is set from cycle T+1.
  - Illegal access: outside all windows, instruction fetch from RAM or IO, data access to ROM, or any write to ROM. Next state DONE with the rdata register set to 0. err_out is set and err_addr_out is loaded with the address.
- ACCESS: sel_out and write_out held stable; counter increments every cycle.
  - Selected slave ready=1: capture that slave's rdata, clear sel_out and write_out, go to DONE.
  - Ready bits of unselected slaves are ignored.
  - Counter reaches TIMEOUT with no ready: clear sel_out, set rdata to 0, set err_out, load err_addr_out, go to DONE.
  - Ready and timeout in the same cycle: ready wins, no error.
- DONE: cpu_ready_out=1 for exactly one cycle with cpu_rdata_out valid, then go to IDLE. cpu_valid_in is not examined in DONE, so a back-to-back request is accepted no earlier than the cycle after DONE.
- Latency: with a zero-wait slave (ready in T+1), cpu_ready_out is high in T+2. Each slave wait cycle adds one cycle.
- cpu_valid_in dropping in ACCESS: the transaction still completes, with no abort; the ready pulse is issued regardless.
- cpu_rdata_out holds its last value outside DONE.
- err_clear_in=1 clears err_out the next cycle. A new error in the same cycle takes priority: err_out stays 1 and err_addr_out is updated.
- Window compare: base <= addr < base+size, computed 33 bits wide so that base+size does not wrap. IO uses addr >= IO_BASE only.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - slave index constants SLV_ROM=0, SLV_RAM=1, SLV_IO=2
  - NUM_SLAVES=3
  - default memory-map constants
- Sub-module addr_decoder, purely combinational: takes addr, instr and write; returns one-hot hit[2:0] and illegal.
- The FSM, timeout counter, rdata mux and error registers stay in bus_controller.

Test Plan:
- ROM fetch: valid=1, instr=1, addr=32'h0000_0010; ROM ready in T+1 with 32'h0000_0013 -> sel_out=3'b001 in T+1, cpu_ready_out in T+2 with rdata 32'h0000_0013, err_out=0.
- RAM write with wait states: addr=32'h0000_1004, wstrb=4'b1111; RAM ready after 3 cycles -> sel_out=3'b010 and write_out=1 for 3 cycles, ready in T+4, no error.
- Illegal accesses: write to 32'h0000_0100, then instr fetch at 32'h1000_0000 -> each gives ready in T+1 with rdata 0, sel_out never asserted, err_out=1, err_addr_out=32'h1000_0000 after the second.
- Timeout: IO read at 32'h1000_0000 with slave never ready, TIMEOUT=15 -> sel_out=3'b100 for 15 cycles then ready with rdata 0, err_out=1, err_addr_out=32'h1000_0000. Also pulse ROM/RAM ready during the wait -> ignored.
- Error clear race: err_clear_in=1 in the same cycle a hole access at 32'h0000_3000 faults -> err_out stays 1, err_addr_out=32'h0000_3000. A later clear alone -> err_out=0.
- Reset mid-ACCESS: assert reset_n_in=0 asynchronously in the second wait cycle -> all outputs 0 immediately, no ready pulse after release, next request served normally.
